rf_write_arbiter: RTL

- Shares the single register_file write port (reg_write_en / destination_reg / write_data) between two requesters.
  - The single-cycle ALU writeback path.
  - The multi-cycle unit (load/mul/div) writeback path.
- Multi-cycle results are buffered in a small in-order FIFO.
- A starvation limiter guarantees those buffered results eventually drain.
- Provides pending-write hit flags so hazard logic can stall readers of registers not yet written.

---
 rtl/rf_arb_pkg.sv | 17 +
 rtl/rf_wr_fifo.sv | 64 ++++++
 rtl/rf_write_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// In-order buffer for multi-cycle writebacks; exposes per-entry addresses for hazard compare.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_push,
  input  wr_req_t                          i_din,
  input  logic                             i_pop,
  output logic                             o_full,
  output logic                             o_empty,
  output wr_req_t                          o_head,
  output logic [DEPTH-1:0]                 o_vld,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]  o_addr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wr_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage and pointers; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_vld[i]  = CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count;
      o_addr[i] = r_mem[i].addr;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the ALU and the buffered multi-cycle path.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = RF_ADDR_W,  // must match RF_ADDR_W of the package
  parameter int unsigned DATA_W       = RF_DATA_W,  // must match RF_DATA_W of the package
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wr_valid,
  output logic              alu_wr_ready,
  input  logic [ADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              mcu_wr_valid,
  output logic              mcu_wr_ready,
  input  logic [ADDR_W-1:0] mcu_wr_addr,
  input  logic [DATA_W-1:0] mcu_wr_data,
  input  logic [ADDR_W-1:0] source1_reg,
  input  logic [ADDR_W-1:0] source2_reg,
  output logic              pend_hit1,
  output logic              pend_hit2,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] destination_reg,
  output logic [DATA_W-1:0] write_data
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t                            r_state;
  arb_state_t                            w_state_nxt;
  logic [SC_W-1:0]                       r_starve_cnt;
  logic [SC_W-1:0]                       w_starve_nxt;
  logic                                  w_alu_win;
  logic                                  w_pop;
  logic                                  w_push;
  logic                                  w_fifo_full;
  logic                                  w_fifo_empty;
  wr_req_t                               w_head;
  wr_req_t                               w_mcu_req;
  wr_req_t                               w_win_req;
  logic [FIFO_DEPTH-1:0]                 w_vld;
  logic [FIFO_DEPTH-1:0][RF_ADDR_W-1:0]  w_addr;

  assign mcu_wr_ready = ~w_fifo_full;
  assign w_push       = mcu_wr_valid & ~w_fifo_full;
  assign w_mcu_req    = '{addr: mcu_wr_addr, data: mcu_wr_data};

  rf_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_mcu_req),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_head),
    .o_vld   (w_vld),
    .o_addr  (w_addr)
  );

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Winner selection, starvation count update and FORCE entry/exit.
  always_comb begin
    w_state_nxt  = r_state;
    alu_wr_ready = 1'b0;
    w_alu_win    = 1'b0;
    w_pop        = 1'b0;
    w_starve_nxt = r_starve_cnt;
    w_win_req    = w_head;

    case (r_state)
      NORMAL: begin
        alu_wr_ready = 1'b1;
        if (alu_wr_valid)       w_alu_win = 1'b1;
        else if (!w_fifo_empty) w_pop     = 1'b1;
      end
      FORCE: begin
        w_pop       = ~w_fifo_empty;
        w_state_nxt = NORMAL;
      end
      default: w_state_nxt = NORMAL;
    endcase

    if (w_pop || w_fifo_empty)                                 w_starve_nxt = '0;
    else if (w_alu_win && r_starve_cnt != SC_W'(STARVE_LIMIT)) w_starve_nxt = r_starve_cnt + SC_W'(1);

    if (r_state == NORMAL && w_starve_nxt == SC_W'(STARVE_LIMIT)) w_state_nxt = FORCE;

    if (w_alu_win) w_win_req = '{addr: alu_wr_addr, data: alu_wr_data};
  end

  // Register-file port register; address 0 is consumed without a write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_en    <= 1'b0;
      destination_reg <= '0;
      write_data      <= '0;
    end else if (w_alu_win || w_pop) begin
      reg_write_en    <= |w_win_req.addr;
      destination_reg <= w_win_req.addr;
      write_data      <= w_win_req.data;
    end else begin
      reg_write_en    <= 1'b0;
    end
  end

  // Pending-write hits against live buffer entries; register 0 never hits.
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (w_vld[i] && (source1_reg != '0) && (w_addr[i] == source1_reg)) pend_hit1 = 1'b1;
      if (w_vld[i] && (source2_reg != '0) && (w_addr[i] == source2_reg)) pend_hit2 = 1'b1;
    end
  end

endmodule
